// File: rtl/spindle_scheduler.sv
// rtl/spindle_scheduler.sv - spindle datapath step sequencer with shadowed gain/damping registers
//
// Walks the shared derivative/integrator datapath across bag1, bag2 and chain
// once per requested step: select fiber, settle, strobe writeback, then strobe
// the muscle combine and pulse step_done. Runtime constants are written into
// shadow registers through the cfg port and copied to the active set only while
// idle with no request pending, so a step always sees one consistent set.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   step_req            level request for one integration step
//   overrun_clr         clears the sticky overrun flag
//   cfg_valid/addr/data config write (addr 0..4 = bdamp_1, bdamp_2, bdamp_chain, gi, gii)
//   cfg_ready           high from the first clock after reset release
//   fiber_sel           0 bag1, 1 bag2, 2 chain, 3 idle
//   wb_en               one-hot fiber writeback strobe
//   muscle_wb           muscle combine strobe
//   step_done           one-cycle end-of-step pulse
//   busy                step in progress
//   overrun             sticky: request seen while busy
//   step_count          completed steps, wraps
//   bdamp_*, gi, gii    active datapath constants

module spindle_scheduler #(
  parameter int          SETTLE_CYCLES   = 2,
  parameter logic [31:0] DEF_BDAMP_1     = 32'h3E71_4120,
  parameter logic [31:0] DEF_BDAMP_2     = 32'h3D14_4674,
  parameter logic [31:0] DEF_BDAMP_CHAIN = 32'h3C58_44D0,
  parameter logic [31:0] DEF_GI          = 32'h469C_4000,
  parameter logic [31:0] DEF_GII         = 32'h45E2_9000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_req,
  input  logic        overrun_clr,
  input  logic        cfg_valid,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        cfg_ready,
  output logic [1:0]  fiber_sel,
  output logic [2:0]  wb_en,
  output logic        muscle_wb,
  output logic        step_done,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] step_count,
  output logic [31:0] bdamp_1,
  output logic [31:0] bdamp_2,
  output logic [31:0] bdamp_chain,
  output logic [31:0] gi,
  output logic [31:0] gii
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WRITE,
    S_COMBINE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_f, w_f_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;

  logic [1:0]  r_fiber_sel, w_fiber_sel_nxt;
  logic [2:0]  r_wb_en, w_wb_en_nxt;
  logic        r_muscle_wb, w_muscle_wb_nxt;
  logic        r_step_done, w_step_done_nxt;
  logic        r_busy;
  logic        r_overrun;
  logic [15:0] r_step_count;
  logic        r_cfg_ready;

  logic        r_pending;
  logic [31:0] r_sh_bdamp_1, r_sh_bdamp_2, r_sh_bdamp_chain, r_sh_gi, r_sh_gii;
  logic [31:0] r_bdamp_1, r_bdamp_2, r_bdamp_chain, r_gi, r_gii;

  logic        w_cfg_wr;
  logic        w_commit;

  // Next state plus output decode from the next state, so every output is a
  // flop that already reflects the state it is about to describe.
  always_comb begin
    w_state_nxt     = r_state;
    w_f_nxt         = r_f;
    w_cnt_nxt       = r_cnt;
    w_fiber_sel_nxt = 2'd3;
    w_wb_en_nxt     = 3'b000;
    w_muscle_wb_nxt = 1'b0;
    w_step_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (step_req) begin
          w_state_nxt = S_ISSUE;
          w_f_nxt     = 2'd0;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_ISSUE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_WRITE: begin
        if (r_f == 2'd2) begin
          w_state_nxt = S_COMBINE;
        end else begin
          w_state_nxt = S_ISSUE;
          w_f_nxt     = r_f + 2'd1;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_COMBINE: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_ISSUE: w_fiber_sel_nxt = w_f_nxt;
      S_WRITE: begin
        w_fiber_sel_nxt = w_f_nxt;
        w_wb_en_nxt     = 3'b001 << w_f_nxt;
      end
      S_COMBINE: begin
        // chain outputs stay selected while the combine consumes them
        w_fiber_sel_nxt = 2'd2;
        w_muscle_wb_nxt = 1'b1;
      end
      S_DONE:  w_step_done_nxt = 1'b1;
      default: w_fiber_sel_nxt = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_f         <= 2'd0;
      r_cnt       <= 4'd0;
      r_fiber_sel <= 2'd3;
      r_wb_en     <= 3'b000;
      r_muscle_wb <= 1'b0;
      r_step_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_f         <= w_f_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fiber_sel <= w_fiber_sel_nxt;
      r_wb_en     <= w_wb_en_nxt;
      r_muscle_wb <= w_muscle_wb_nxt;
      r_step_done <= w_step_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // A request is judged against the current state: anything other than IDLE
  // (including DONE) drops it and flags overrun. Set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun    <= 1'b0;
      r_step_count <= 16'd0;
      r_cfg_ready  <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b1;
      if (step_req && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
      if (r_state == S_DONE) begin
        r_step_count <= r_step_count + 16'd1;
      end
    end
  end

  assign w_cfg_wr = cfg_valid && (cfg_addr <= 3'd4);
  // Holding off while step_req is high keeps the active set stable in the
  // cycle a step launches.
  assign w_commit = (r_state == S_IDLE) && !step_req && r_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending        <= 1'b0;
      r_sh_bdamp_1     <= DEF_BDAMP_1;
      r_sh_bdamp_2     <= DEF_BDAMP_2;
      r_sh_bdamp_chain <= DEF_BDAMP_CHAIN;
      r_sh_gi          <= DEF_GI;
      r_sh_gii         <= DEF_GII;
    end else begin
      // a write landing on a commit cycle keeps pending so it commits next time
      if (w_cfg_wr) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_cfg_wr) begin
        case (cfg_addr)
          3'd0:    r_sh_bdamp_1     <= cfg_data;
          3'd1:    r_sh_bdamp_2     <= cfg_data;
          3'd2:    r_sh_bdamp_chain <= cfg_data;
          3'd3:    r_sh_gi          <= cfg_data;
          default: r_sh_gii         <= cfg_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bdamp_1     <= DEF_BDAMP_1;
      r_bdamp_2     <= DEF_BDAMP_2;
      r_bdamp_chain <= DEF_BDAMP_CHAIN;
      r_gi          <= DEF_GI;
      r_gii         <= DEF_GII;
    end else if (w_commit) begin
      r_bdamp_1     <= r_sh_bdamp_1;
      r_bdamp_2     <= r_sh_bdamp_2;
      r_bdamp_chain <= r_sh_bdamp_chain;
      r_gi          <= r_sh_gi;
      r_gii         <= r_sh_gii;
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign fiber_sel   = r_fiber_sel;
  assign wb_en       = r_wb_en;
  assign muscle_wb   = r_muscle_wb;
  assign step_done   = r_step_done;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign step_count  = r_step_count;
  assign bdamp_1     = r_bdamp_1;
  assign bdamp_2     = r_bdamp_2;
  assign bdamp_chain = r_bdamp_chain;
  assign gi          = r_gi;
  assign gii         = r_gii;

endmodule

// File: doc/spindle_scheduler.md
Name: spindle_scheduler

Overview:
Sequencer for the shared spindle derivative/integrator datapath. It sweeps the datapath across bag1, bag2 and chain once per requested integration step. For each fiber it drives the fiber select, waits a configurable settle time, then strobes that fiber's state writeback, and finishes with a muscle-combine strobe. It also owns the runtime gain/damping registers (BDAMP_1/2/chain, GI, GII), which a host loads through a config port; new values are applied only between steps.

Parameters:
SETTLE_CYCLES, 2, cycles fiber_sel is held before the writeback strobe (1..15)
DEF_BDAMP_1, 32'h3E71_4120, reset value of bdamp_1 (0.2356)
DEF_BDAMP_2, 32'h3D14_4674, reset value of bdamp_2 (0.0362)
DEF_BDAMP_CHAIN, 32'h3C58_44D0, reset value of bdamp_chain (0.0132)
DEF_GI, 32'h469C_4000, reset value of gi (20000)
DEF_GII, 32'h45E2_9000, reset value of gii (7250)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
step_req  in  1  request one integration step (level, sampled each clk)
overrun_clr  in  1  clears overrun
cfg_valid  in  1  config write strobe
cfg_addr  in  3  0=bdamp_1 1=bdamp_2 2=bdamp_chain 3=gi 4=gii
cfg_data  in  32  IEEE-754 value
cfg_ready  out  1  always 1 out of reset
fiber_sel  out  2  datapath select: 0 bag1, 1 bag2, 2 chain, 3 idle
wb_en  out  3  one-hot fiber state writeback strobe
muscle_wb  out  1  Ia/II muscle combine strobe
step_done  out  1  one-cycle end-of-step pulse
busy  out  1  step in progress
overrun  out  1  sticky: step_req seen while busy
step_count  out  16  completed steps, wraps
bdamp_1, bdamp_2, bdamp_chain, gi, gii  out  32 each  active datapath constants

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; fiber_sel=3; wb_en=0; muscle_wb=0; step_done=0; busy=0; overrun=0; step_count=0; cfg_ready=0.
  - Active and shadow registers load their DEF_* values; pending=0.
  - A reset in the middle of a step aborts it and emits no strobes.
  - cfg_ready goes to 1 on the first clk after reset is released.
- FSM states: IDLE, ISSUE, WRITE, COMBINE, DONE. Internal fiber index f counts 0..2; settle counter is 4 bits.
- IDLE: fiber_sel=3. If step_req=1 at an edge, go to ISSUE with f=0 and settle counter cleared.
- ISSUE: fiber_sel=f. Stay SETTLE_CYCLES cycles, then go to WRITE.
- WRITE: one cycle; fiber_sel=f; wb_en[f]=1.
  - If f<2: f increments and the FSM returns to ISSUE.
  - If f=2: go to COMBINE.
- COMBINE: one cycle; muscle_wb=1; fiber_sel=2 (chain outputs remain valid while combining).
- DONE: one cycle; step_done=1; fiber_sel=3; step_count increments at the exit edge (0xFFFF wraps to 0). Next state is IDLE.
- Step timing:
  - A step occupies 3*(SETTLE_CYCLES+1)+2 cycles, which is 11 cycles at the default.
  - busy = (state != IDLE).
  - There is no back-to-back issue: IDLE always lasts at least 1 cycle between steps.
- All outputs are registered, decoded from the next state. They change only on clk edges.
- Overrun:
  - step_req=1 while busy=1 sets overrun; the request is dropped, not queued.
  - overrun_clr clears overrun.
  - If set and clear occur in the same cycle, set wins.
  - The request is judged in DONE (busy=1), so step_req=1 during DONE is an overrun.
- Config path:
  - cfg_valid=1 with cfg_addr 0..4 writes the shadow register and sets pending.
  - cfg_addr 5..7 is ignored; pending is unchanged.
  - Writes are accepted in every state.
- Commit:
  - The commit condition is state=IDLE and step_req=0 and pending=1. On commit, all five active registers copy their shadows and pending clears.
  - Active registers therefore never change while busy, or in the cycle a step starts.
  - A cfg write in the same cycle as a commit: the commit takes the old shadow, and pending stays 1, so the new value commits at the next eligible cycle.
- No arithmetic on cfg_data; values pass through bit-exact.

Test Plan:
- Reset release, then step_req high for 1 cycle (SETTLE_CYCLES=2) -> cycles 1-2 fiber_sel=0; cycle 3 wb_en=001; cycles 4-5 fiber_sel=1; cycle 6 wb_en=010; cycles 7-8 fiber_sel=2; cycle 9 wb_en=100; cycle 10 muscle_wb=1; cycle 11 step_done=1; step_count=1; busy=0 at cycle 12.
- step_req held high continuously for 40 cycles -> steps start 12 cycles apart; exactly 3 step_done pulses; overrun=1; overrun_clr then clears it.
- cfg write addr 3 data 32'h4700_0000 while busy -> gi stays 32'h469C_4000 until the first IDLE cycle with step_req=0, then becomes 32'h4700_0000.
- cfg write addr 6 -> no shadow or active change, pending stays 0; addr 0 write in the same cycle as a commit -> bdamp_1 updates one eligible cycle later.
- Reset asserted during WRITE of f=1 -> all outputs go to reset values immediately; step_count unchanged at 0; a fresh step_req afterwards completes normally.
- step_count preloaded by 65535 steps, then one more step -> wraps to 0 with normal strobes.
